// File: rtl/vga_fb_pkg.sv
// Shared constants, CPU op encodings and FSM states for the framebuffer port-B arbiter.
package vga_fb_pkg;

    localparam int ROWS = 480;
    localparam int COLS = 480;
    localparam int AW   = 9;

    typedef enum logic [1:0] {
        OP_SET  = 2'b00,
        OP_CLR  = 2'b01,
        OP_WROW = 2'b10,
        OP_RROW = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RADDR  = 3'd1,
        RWAIT  = 3'd2,
        MODIFY = 3'd3,
        WRITE  = 3'd4,
        ACK    = 3'd5
    } state_t;

endpackage

// File: rtl/vga_fb_port_arbiter_if.sv
// CPU request/ack bus into the framebuffer arbiter; req and fields are held stable until ack.
interface vga_fb_port_arbiter_if #(
    parameter int COLS = vga_fb_pkg::COLS
);
    import vga_fb_pkg::*;

    logic            req;
    op_t             op;
    logic [AW-1:0]   x;
    logic [AW-1:0]   y;
    logic [COLS-1:0] row_din;
    logic            ack;
    logic            err;
    logic [COLS-1:0] row_dout;

    modport master (
        output req, op, x, y, row_din,
        input  ack, err, row_dout
    );

    modport slave (
        input  req, op, x, y, row_din,
        output ack, err, row_dout
    );

endinterface

// File: rtl/vga_fb_clear_seq.sv
// Full-frame clear sequencer: requests one row write per grant, clr_done pulses once the last row lands.
// Requests stay up until granted; clr_start is ignored while a clear is running.
module vga_fb_clear_seq #(
    parameter int ROWS = vga_fb_pkg::ROWS
) (
    input  logic                      clk_50,
    input  logic                      rst,
    input  logic                      clr_start,
    input  logic                      clr_grant,
    output logic                      clr_req,
    output logic [vga_fb_pkg::AW-1:0] clr_row,
    output logic                      clr_busy,
    output logic                      clr_done
);
    import vga_fb_pkg::*;

    localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);

    // Set when the last row has been granted; its write lands on the next edge.
    logic last_sent;

    assign clr_req = clr_busy && !last_sent;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            clr_row   <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            last_sent <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            if (last_sent) begin
                clr_busy  <= 1'b0;
                last_sent <= 1'b0;
                clr_done  <= 1'b1;
            end else if (clr_grant) begin
                if (clr_row == ROW_LAST) begin
                    last_sent <= 1'b1;
                end else begin
                    clr_row <= clr_row + 1'b1;
                end
            end else if (clr_start && !clr_busy) begin
                clr_busy <= 1'b1;
                clr_row  <= '0;
            end
        end
    end

endmodule

// File: rtl/vga_fb_port_arbiter.sv
// Port-B owner of the 1-bit framebuffer: CPU pixel RMW / row write / row read, round-robin with the clear sequencer.
// Ack latency from grant: pixel 5, row write 2, row read 4, range error 1; a CPU op waits at most one clear row.
module vga_fb_port_arbiter #(
    parameter int ROWS = vga_fb_pkg::ROWS,
    parameter int COLS = vga_fb_pkg::COLS
) (
    input  logic                      clk_50,
    input  logic                      rst,
    vga_fb_port_arbiter_if.slave      cpu,
    input  logic                      clr_start,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic                      fb_we,
    output logic [vga_fb_pkg::AW-1:0] fb_addr,
    output logic [COLS-1:0]           fb_din,
    input  logic [COLS-1:0]           fb_dout
);
    import vga_fb_pkg::*;

    localparam logic [AW-1:0] ROW_LIM = AW'(ROWS);
    localparam logic [AW-1:0] COL_LIM = AW'(COLS);

    state_t          state, state_d;
    logic            last_grant, last_grant_d;   // 1: clear sequencer was granted last
    logic            own_clr, own_clr_d;
    op_t             op_q, op_q_d;
    logic [AW-1:0]   x_q, x_q_d;

    logic            fb_we_d;
    logic [AW-1:0]   fb_addr_d;
    logic [COLS-1:0] fb_din_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [COLS-1:0] row_dout_q, row_dout_d;
    logic [COLS-1:0] row_mod;

    logic            cpu_pix;
    logic            cpu_bad;
    logic            pick_cpu;
    logic            pick_clr;
    logic            clr_req;
    logic [AW-1:0]   clr_row;

    vga_fb_clear_seq #(.ROWS(ROWS)) u_clear_seq (
        .clk_50    (clk_50),
        .rst       (rst),
        .clr_start (clr_start),
        .clr_grant (pick_clr),
        .clr_req   (clr_req),
        .clr_row   (clr_row),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    assign cpu.ack      = ack_q;
    assign cpu.err      = err_q;
    assign cpu.row_dout = row_dout_q;

    assign cpu_pix  = (cpu.op == OP_SET) || (cpu.op == OP_CLR);
    assign cpu_bad  = (cpu.y >= ROW_LIM) || (cpu_pix && (cpu.x >= COL_LIM));
    assign pick_cpu = (state == IDLE) && cpu.req && (!clr_req || last_grant);
    assign pick_clr = (state == IDLE) && clr_req && (!cpu.req || !last_grant);

    // fb_addr is held through RADDR..MODIFY, so fb_dout is the target row in MODIFY.
    always_comb begin
        row_mod        = fb_dout;
        row_mod[x_q]   = (op_q == OP_SET);
    end

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        own_clr_d    = own_clr;
        op_q_d       = op_q;
        x_q_d        = x_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr;
        fb_din_d     = fb_din;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        row_dout_d   = row_dout_q;

        case (state)
            IDLE: begin
                if (pick_cpu) begin
                    last_grant_d = 1'b0;
                    own_clr_d    = 1'b0;
                    op_q_d       = cpu.op;
                    x_q_d        = cpu.x;
                    if (cpu_bad) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else if (cpu.op == OP_WROW) begin
                        state_d   = WRITE;
                        fb_we_d   = 1'b1;
                        fb_addr_d = cpu.y;
                        fb_din_d  = cpu.row_din;
                    end else begin
                        state_d   = RADDR;
                        fb_addr_d = cpu.y;
                    end
                end else if (pick_clr) begin
                    last_grant_d = 1'b1;
                    own_clr_d    = 1'b1;
                    state_d      = WRITE;
                    fb_we_d      = 1'b1;
                    fb_addr_d    = clr_row;
                    fb_din_d     = '0;
                end
            end
            RADDR:  state_d = RWAIT;
            RWAIT:  state_d = MODIFY;
            MODIFY: begin
                if (op_q == OP_RROW) begin
                    state_d    = ACK;
                    ack_d      = 1'b1;
                    row_dout_d = fb_dout;
                end else begin
                    state_d  = WRITE;
                    fb_we_d  = 1'b1;
                    fb_din_d = row_mod;
                end
            end
            WRITE: begin
                if (own_clr) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            own_clr    <= 1'b0;
            op_q       <= OP_SET;
            x_q        <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_din     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            row_dout_q <= '0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            own_clr    <= own_clr_d;
            op_q       <= op_q_d;
            x_q        <= x_q_d;
            fb_we      <= fb_we_d;
            fb_addr    <= fb_addr_d;
            fb_din     <= fb_din_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            row_dout_q <= row_dout_d;
        end
    end

endmodule

// File: tb/tb_vga_fb_port_arbiter.sv
// Directed bench for vga_fb_port_arbiter with a 1-cycle synchronous-read framebuffer model on port B.
module tb_vga_fb_port_arbiter;
    import vga_fb_pkg::*;

    localparam int R = ROWS;
    localparam int C = COLS;

    logic clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    logic         rst;
    logic         clr_start;
    logic         clr_busy;
    logic         clr_done;
    logic         fb_we;
    logic [8:0]   fb_addr;
    logic [C-1:0] fb_din;
    logic [C-1:0] fb_dout;

    vga_fb_port_arbiter_if #(.COLS(C)) cpu ();

    vga_fb_port_arbiter #(.ROWS(R), .COLS(C)) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .cpu       (cpu),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_din    (fb_din),
        .fb_dout   (fb_dout)
    );

    logic [C-1:0] mem [R];
    always @(posedge clk_50) begin
        if (fb_we) mem[fb_addr] <= fb_din;
        fb_dout <= mem[fb_addr];
    end

    int we_run = 0;
    int we_run_max = 0;
    always @(posedge clk_50) begin
        if (fb_we) we_run = we_run + 1;
        else       we_run = 0;
        if (we_run > we_run_max) we_run_max = we_run;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk_i(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_r(input string name, input logic [C-1:0] act, input logic [C-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        chk_i({pfx, "_ack"},  int'(cpu.ack),  0);
        chk_i({pfx, "_err"},  int'(cpu.err),  0);
        chk_i({pfx, "_busy"}, int'(clr_busy), 0);
        chk_i({pfx, "_done"}, int'(clr_done), 0);
        chk_i({pfx, "_we"},   int'(fb_we),    0);
        chk_i({pfx, "_addr"}, int'(fb_addr),  0);
        chk_r({pfx, "_din"},  fb_din,         '0);
        chk_r({pfx, "_dout"}, cpu.row_dout,   '0);
    endtask

    // Latency n = index of the edge after req rises (edge 1 grants when the FSM is idle and uncontested).
    task automatic cpu_op(input op_t op, input logic [8:0] x, input logic [8:0] y, input logic [C-1:0] din,
                          output int lat, output int we_n, output int we_at,
                          output logic err, output logic [C-1:0] dout);
        cpu.req = 1'b1; cpu.op = op; cpu.x = x; cpu.y = y; cpu.row_din = din;
        lat = 99; we_n = 0; we_at = 0; err = 1'b0; dout = '0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk_50); #1;
            if (fb_we) begin
                we_n++;
                if (we_at == 0) we_at = n;
            end
            if (cpu.ack) begin
                lat = n; err = cpu.err; dout = cpu.row_dout;
                break;
            end
        end
        cpu.req = 1'b0;
        @(posedge clk_50); #1;
    endtask

    typedef struct {
        op_t          op;
        logic [8:0]   x;
        logic [8:0]   y;
        logic [C-1:0] din;
        int           lat;
        logic         err;
        int           we_at;
        logic [C-1:0] dout;
    } vec_t;

    function automatic vec_t mk(op_t op, int x, int y, logic [C-1:0] din,
                                int lat, logic err, int we_at, logic [C-1:0] dout);
        vec_t v;
        v.op = op; v.x = 9'(x); v.y = 9'(y); v.din = din;
        v.lat = lat; v.err = err; v.we_at = we_at; v.dout = dout;
        return v;
    endfunction

    vec_t         vt[$];
    int           lat, wn, wa, bad, seen, busy_seen;
    logic         er;
    logic [C-1:0] dv, exp_row;
    logic [C-1:0] pat, pat_c2, one0, top, bit101;

    initial begin
        rst = 1'b1; clr_start = 1'b0;
        cpu.req = 1'b0; cpu.op = OP_SET; cpu.x = '0; cpu.y = '0; cpu.row_din = '0;
        pat    = {60{8'hA5}};
        pat_c2 = {{59{8'hA5}}, 8'hA1};
        one0   = C'(1);
        top    = one0 << 479;
        bit101 = one0 << 101;

        repeat (3) @(posedge clk_50);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk_50); #1;

        // Fill every row with ones through the CPU row-write path.
        bad = 0;
        for (int r = 0; r < R; r++) begin
            cpu_op(OP_WROW, 9'd0, 9'(r), '1, lat, wn, wa, er, dv);
            if (lat != 2) bad++;
        end
        chk_i("fill_acks", bad, 0);

        // Full clear with a second, ignored clr_start part-way through.
        clr_start = 1'b1;
        @(posedge clk_50); #1;
        clr_start = 1'b0;
        chk_i("clr_busy_set", int'(clr_busy), 1);
        lat = 0; wn = 0;
        for (int n = 1; n <= 2000; n++) begin
            clr_start = (n == 100);
            @(posedge clk_50); #1;
            if (fb_we) wn++;
            if (clr_done) begin
                lat = n;
                break;
            end
        end
        clr_start = 1'b0;
        chk_i("clr_cycles", lat, 960);
        chk_i("clr_writes", wn, 480);
        chk_i("clr_busy_end", int'(clr_busy), 0);
        @(posedge clk_50); #1;
        chk_i("clr_done_pulse", int'(clr_done), 0);
        bad = 0;
        for (int r = 0; r < R; r++) if (mem[r] !== '0) bad++;
        chk_i("clr_rows_zero", bad, 0);

        vt.push_back(mk(OP_SET,    0,   0, '0,  5, 1'b0, 4, '0));
        vt.push_back(mk(OP_RROW,   0,   0, '0,  4, 1'b0, 0, one0));
        vt.push_back(mk(OP_SET,  479, 479, '0,  5, 1'b0, 4, '0));
        vt.push_back(mk(OP_RROW,   0, 479, '0,  4, 1'b0, 0, top));
        vt.push_back(mk(OP_WROW,   0,   5, pat, 2, 1'b0, 1, '0));
        vt.push_back(mk(OP_CLR,    2,   5, '0,  5, 1'b0, 4, '0));
        vt.push_back(mk(OP_RROW,   0,   5, '0,  4, 1'b0, 0, pat_c2));
        vt.push_back(mk(OP_SET,  480,   0, '0,  1, 1'b1, 0, '0));
        vt.push_back(mk(OP_CLR,    0, 500, '0,  1, 1'b1, 0, '0));
        vt.push_back(mk(OP_WROW,   0, 500, pat, 1, 1'b1, 0, '0));
        vt.push_back(mk(OP_RROW,   0, 480, '0,  1, 1'b1, 0, '0));
        vt.push_back(mk(OP_RROW,   0,   0, '0,  4, 1'b0, 0, one0));
        vt.push_back(mk(OP_RROW,   0, 200, '0,  4, 1'b0, 0, '0));
        vt.push_back(mk(OP_SET,  100, 200, '0,  5, 1'b0, 4, '0));
        vt.push_back(mk(OP_SET,  101, 200, '0,  5, 1'b0, 4, '0));
        vt.push_back(mk(OP_CLR,  100, 200, '0,  5, 1'b0, 4, '0));
        vt.push_back(mk(OP_RROW,   0, 200, '0,  4, 1'b0, 0, bit101));
        vt.push_back(mk(OP_CLR,  479,   0, '0,  5, 1'b0, 4, '0));
        vt.push_back(mk(OP_RROW,   0,   0, '0,  4, 1'b0, 0, one0));
        vt.push_back(mk(OP_WROW, 500,   7, pat, 2, 1'b0, 1, '0));
        vt.push_back(mk(OP_RROW, 511,   7, '0,  4, 1'b0, 0, pat));

        foreach (vt[i]) begin
            cpu_op(vt[i].op, vt[i].x, vt[i].y, vt[i].din, lat, wn, wa, er, dv);
            chk_i($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk_i($sformatf("v%0d_err", i), int'(er), int'(vt[i].err));
            chk_i($sformatf("v%0d_we_n", i), wn, (vt[i].we_at != 0) ? 1 : 0);
            chk_i($sformatf("v%0d_we_at", i), wa, vt[i].we_at);
            if (vt[i].op == OP_RROW && !vt[i].err)
                chk_r($sformatf("v%0d_dout", i), dv, vt[i].dout);
        end

        // Interleave: each CPU op waits exactly one clear row (2 cycles) before its 5-cycle RMW.
        // Even ops hit an already-cleared row (bit survives); odd ops hit rows 200+ that get cleared later.
        clr_start = 1'b1;
        @(posedge clk_50); #1;
        clr_start = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) cpu_op(OP_SET, 9'(k), 9'(k),       '0, lat, wn, wa, er, dv);
            else            cpu_op(OP_SET, 9'(k), 9'(k + 200), '0, lat, wn, wa, er, dv);
            if (lat != 7 || er) bad++;
        end
        chk_i("ilv_cpu_lat", bad, 0);
        seen = 0;
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk_50); #1;
            if (clr_done) begin
                seen = 1;
                break;
            end
        end
        chk_i("ilv_done", seen, 1);
        @(posedge clk_50); #1;
        bad = 0;
        for (int r = 0; r < R; r++) begin
            exp_row = '0;
            if (r < 20 && r % 2 == 0) exp_row[r] = 1'b1;
            if (mem[r] !== exp_row) bad++;
        end
        chk_i("ilv_final_rows", bad, 0);

        // Reset while a row write sits in WRITE.
        cpu.req = 1'b1; cpu.op = OP_WROW; cpu.x = '0; cpu.y = 9'd9; cpu.row_din = '1;
        @(posedge clk_50); #1;
        chk_i("rw_we_in_write", int'(fb_we), 1);
        rst = 1'b1; cpu.req = 1'b0;
        @(posedge clk_50); #1;
        check_zero("rw_reset");
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk_50); #1;
            if (cpu.ack || fb_we) seen++;
        end
        chk_i("rw_no_ack", seen, 0);

        // Reset part-way through a clear.
        clr_start = 1'b1;
        @(posedge clk_50); #1;
        clr_start = 1'b0;
        repeat (100) @(posedge clk_50);
        #1;
        chk_i("mc_busy_mid", int'(clr_busy), 1);
        rst = 1'b1;
        @(posedge clk_50); #1;
        check_zero("mc_reset");
        rst = 1'b0;
        seen = 0; busy_seen = 0;
        for (int n = 0; n < 1100; n++) begin
            @(posedge clk_50); #1;
            if (clr_done) seen++;
            if (clr_busy || fb_we) busy_seen++;
        end
        chk_i("mc_no_done", seen, 0);
        chk_i("mc_idle", busy_seen, 0);

        chk_i("we_single_cycle", we_run_max, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_fb_port_arbiter.md
# vga_fb_port_arbiter

Owns port B of the 480×480 one-bit framebuffer RAM (480 rows × 480 bits, 1-cycle synchronous read) and shares it between the CPU bus and an internal full-frame clear sequencer. The CPU gets pixel set/clear (read-modify-write), whole-row write and whole-row read. The clear sequencer zeroes all 480 rows on command. The display scan keeps exclusive use of port A and is unaffected.

## Interface
Parameters:
- ROWS, 480, number of framebuffer rows; valid y is 0..ROWS-1.
- COLS, 480, row width in bits; valid x is 0..COLS-1.

Ports:
- clk_50  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU request; held high with fields stable until cpu_ack.
- cpu_op  in  2  00 set pixel, 01 clear pixel, 10 write row, 11 read row.
- cpu_x  in  9  pixel column; ignored for row ops.
- cpu_y  in  9  row index.
- cpu_row_din  in  480  row data for write row.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid only with cpu_ack; 1 means x or y was out of range.
- cpu_row_dout  out  480  row data; valid with cpu_ack for read row.
- clr_start  in  1  one-cycle pulse that starts a full clear.
- clr_busy  out  1  high while a clear is in progress.
- clr_done  out  1  one-cycle pulse after row ROWS-1 is written.
- fb_we  out  1  port-B write enable.
- fb_addr  out  9  port-B row address.
- fb_din  out  480  port-B write data.
- fb_dout  in  480  port-B read data.

## Operation
- All outputs are registered. Reset values are 0 for every output, and the FSM returns to IDLE.
- FSM states:
  - IDLE: arbitrate.
  - RADDR: fb_addr=y, fb_we=0.
  - RWAIT: RAM samples the address.
  - MODIFY: capture fb_dout into row_q, then set or clear bit x.
  - WRITE: fb_we=1 for exactly one cycle.
  - ACK: cpu_ack=1.
- Paths through the FSM:
  - set/clear pixel: IDLE→RADDR→RWAIT→MODIFY→WRITE→ACK→IDLE.
  - write row: IDLE→WRITE→ACK→IDLE. fb_din=cpu_row_din.
  - read row: IDLE→RADDR→RWAIT→MODIFY→ACK. cpu_row_dout=captured row; no write is issued.
  - clear row: IDLE→WRITE→IDLE. fb_din=0, fb_addr=clr_row, no ack.
- Pixel mapping: x maps to bit x of the row, with bit 0 as the leftmost displayed pixel. Only bit x may change; the other 479 bits are written back unchanged.
- Range check is done in IDLE. If x≥COLS (pixel ops) or y≥ROWS, the FSM goes straight to ACK with cpu_err=1 and makes no RAM access.
- Arbitration in IDLE is round-robin between the CPU and the clear sequencer, using a last_grant flag.
  - After reset, last_grant favours the CPU.
  - When both request, the one not granted last wins.
  - The clear sequencer therefore interleaves one row per grant with CPU ops.
- Clear sequencer:
  - clr_start while clr_busy=0 sets clr_busy and clr_row=0.
  - clr_start while clr_busy=1 is ignored.
  - clr_row increments after each clear write.
  - After the write of row ROWS-1: clr_busy←0 and clr_done pulses in the following cycle.
- A CPU request is sampled only in IDLE. If cpu_req is still high in the cycle after ACK, it is treated as a new request.

## Timing
- Latency is counted from the IDLE edge that grants the CPU:
  - set/clear pixel: cpu_ack in cycle 5, fb_we in cycle 4.
  - write row: cpu_ack in cycle 2, fb_we in cycle 1.
  - read row: cpu_ack in cycle 4.
  - error: cpu_ack in cycle 1.
- A full clear with no CPU traffic takes 2×ROWS=960 cycles from clr_start to clr_done.
- A CPU op can be delayed by at most one clear-row write (2 cycles) before it is granted.
- fb_we is never high for more than one consecutive cycle per operation.
- Reset during any state takes effect on the next edge:
  - fb_we goes to 0 and the FSM goes to IDLE.
  - Any pending ack is dropped and any clear is aborted (clr_busy=0, no clr_done).
  - A row partially modified by a RMW is left as it was before that RMW.
- If a CPU row write and a clear target the same row, the final contents follow grant order.

## Structure
- Package vga_fb_pkg holds:
  - the ROWS and COLS constants;
  - op encodings OP_SET, OP_CLR, OP_WROW, OP_RROW;
  - the FSM state enum.
- Sub-module vga_fb_clear_seq holds clr_row, clr_busy and clr_done. It raises a request and advances clr_row on grant.
- The RAM model for simulation is 1-cycle synchronous read, with write data taking effect at the next edge.

## Test plan
- Set pixel: after reset, clear then set pixel x=0,y=0 and x=479,y=479 → rows 0 and 479 read back with only bit 0 and only bit 479 set respectively; each cpu_ack exactly 5 cycles after grant.
- RMW preservation: write row 5 with pattern A5A5…, clear pixel x=2 → row 5 reads back as the pattern with bit 2 cleared and the other 479 bits unchanged.
- Range error: op with x=480 or y=500 → cpu_ack with cpu_err=1 in cycle 1; fb_we never asserts.
- Full clear: fill all rows with 1s, pulse clr_start → clr_done after 960 cycles; all rows read 0. A second clr_start during busy changes nothing.
- Interleaving: CPU pixel ops issued continuously during a clear → grants alternate, every row is cleared, all CPU ops are acked, and the final state matches a reference model.
- Reset mid-op: assert rst in the WRITE state and again mid-clear → fb_we=0 next cycle, no cpu_ack or clr_done; all outputs are 0.
